rob_multi: RTL and testbench
============================

Name: rob_multi

Overview:
Parametrised reorder buffer, successor to the fixed single-writer ROB behind the tail stage. Decode allocates entries in program order. NUM_CMP completion channels (ALU, M5, dcache) write results out of order. The head retires in order to write-back through a valid/ready handshake. Adds exception tagging, precise flush and an occupancy count.

Parameters:
DEPTH, 8, number of entries; power of 2, at least 2
DATA_W, 32, result and PC width
REG_AW, 5, destination register address width
NUM_CMP, 3, number of completion channels
TAG_W, $clog2(DEPTH), entry index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
alloc_valid  in  1  decode requests an entry
alloc_ready  out  1  entry available (not full)
alloc_pc  in  DATA_W  instruction PC
alloc_rd  in  REG_AW  destination register
alloc_w  in  1  instruction writes a register
alloc_store  in  1  instruction is a store
alloc_tag  out  TAG_W  index assigned to this allocation (current tail)
cmp_valid  in  NUM_CMP  per-channel completion strobe
cmp_tag  in  NUM_CMP*TAG_W  packed tags; channel i occupies [i*TAG_W +: TAG_W]
cmp_val  in  NUM_CMP*DATA_W  packed results
cmp_exc  in  NUM_CMP  per-channel exception flag
commit_valid  out  1  head entry is done
commit_ready  in  1  write-back accepts the entry
commit_pc  out  DATA_W  head PC
commit_rd  out  REG_AW  head destination register
commit_w  out  1  head writes a register; forced 0 if head has an exception
commit_store  out  1  head is a store
commit_val  out  DATA_W  head result
commit_exc  out  1  head has an exception
flush  in  1  external pipeline flush, e.g. branch mispredict
count  out  TAG_W+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous): head=0, tail=0, count=0, all entry busy/done/exc bits 0. Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, commit_exc=0. Payload outputs drive the contents of entry 0, which are 0 after reset.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Per-entry state: busy, done, exc, pc, rd, w, store, val.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Entry[tail] gets busy=1, done=0, exc=0 and the payload.
  - tail increments modulo DEPTH.
  - alloc_ready = (count != DEPTH). It is not combinationally relaxed by a same-cycle commit.
- Completion:
  - Channel i with cmp_valid[i] and busy[cmp_tag_i]=1 sets done=1, val=cmp_val_i, exc=cmp_exc_i.
  - A completion to a non-busy entry is ignored.
  - If two channels target the same tag in one cycle, the lowest channel index wins.
  - A completion takes effect at the clock edge. commit_valid for that entry is visible the following cycle at the earliest, so minimum completion-to-commit latency is 1 cycle.
- Commit:
  - commit_valid = busy[head] && done[head]. commit_* outputs are combinational from entry[head].
  - The handshake fires when commit_valid && commit_ready: busy[head] clears and head increments modulo DEPTH.
  - commit_valid holds, with stable payload, until accepted.
- Exception flush:
  - An accepted commit with commit_exc=1 clears all busy bits, sets head=tail=0 and count=0 at that edge.
  - Allocation in that same cycle is dropped.
- External flush:
  - flush=1 gives the same clear as an exception flush.
  - It has priority over alloc, completion and commit in that cycle. The commit handshake is suppressed and commit_valid is masked to 0 while flush=1.
- count:
  - +1 on allocation, -1 on commit, unchanged when both fire.
  - Range 0..DEPTH, registered.
- Wrap-around: head and tail are TAG_W bits wide. Full versus empty is distinguished only by count.
- Simultaneous allocation and commit while full: the commit proceeds and the allocation is not accepted (alloc_ready=0). The next cycle count=DEPTH-1.

Test Plan:
- Reset/idle: DEPTH=4, hold reset=0 then release -> alloc_ready=1, count=0, commit_valid=0, alloc_tag=0.
- Fill to full: 4 back-to-back allocations, commit_ready=0 -> tags 0,1,2,3. Then count=4, alloc_ready=0, and a 5th alloc_valid is not accepted.
- Out-of-order completion:
  - Allocate tags 0..2 (rd=1,2,3). Complete tag2 val=30, then tag0 val=10 (ch1), then tag1 val=20 (ch2).
  - Commits occur in order rd1=10, rd2=20, rd3=30, each 1 cycle after the enabling completion.
- Same-tag conflict: ch0 and ch2 both complete tag1 with 5 and 9 in one cycle -> commit_val=5.
- Wrap and backpressure:
  - Run 10 alloc/commit pairs with commit_ready toggling every cycle. Tags wrap 3->0.
  - commit payload stays stable while commit_ready=0. count never exceeds 4.
- Exception and flush:
  - Allocate 3 entries; tag0 completes with cmp_exc=1. Commit -> commit_exc=1, commit_w=0. Next cycle count=0, commit_valid=0, alloc_tag=0.
  - Separately, assert flush with 2 entries done -> no commit; count=0.

Source files
------------

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - parametrised reorder buffer with multi-channel out-of-order completion
//
// Decode allocates entries at the tail in program order. NUM_CMP completion
// channels mark entries done out of order. The head retires in order through
// a valid/ready handshake. An accepted excepting commit, or an external flush,
// clears the whole buffer.
//
// Ports:
//   clk, reset (async, active-low)
//   alloc_valid/alloc_ready/alloc_pc/alloc_rd/alloc_w/alloc_store/alloc_tag : allocation
//   cmp_valid/cmp_tag/cmp_val/cmp_exc  : packed completion channels (channel i at [i*W +: W])
//   commit_valid/commit_ready/commit_* : in-order retirement of the head entry
//   flush : clears all entries, has priority over everything else in its cycle
//   count : occupancy, 0..DEPTH
module rob_multi #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_CMP = 3,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [DATA_W-1:0]         alloc_pc,
    input  logic [REG_AW-1:0]         alloc_rd,
    input  logic                      alloc_w,
    input  logic                      alloc_store,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [NUM_CMP-1:0]        cmp_valid,
    input  logic [NUM_CMP*TAG_W-1:0]  cmp_tag,
    input  logic [NUM_CMP*DATA_W-1:0] cmp_val,
    input  logic [NUM_CMP-1:0]        cmp_exc,
    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [DATA_W-1:0]         commit_pc,
    output logic [REG_AW-1:0]         commit_rd,
    output logic                      commit_w,
    output logic                      commit_store,
    output logic [DATA_W-1:0]         commit_val,
    output logic                      commit_exc,
    input  logic                      flush,
    output logic [TAG_W:0]            count
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d, exc_q, exc_d;
    logic [DEPTH-1:0]  w_q, w_d, store_q, store_d;
    logic [DATA_W-1:0] pc_q [DEPTH];
    logic [DATA_W-1:0] pc_d [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [DATA_W-1:0] val_d [DEPTH];
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [REG_AW-1:0] rd_d [DEPTH];

    logic             alloc_fire, commit_fire, clear_all;
    logic [TAG_W-1:0] tag_i;

    assign alloc_ready  = (count_q != FULL_CNT);
    assign alloc_tag    = tail_q;
    assign count        = count_q;
    // flush masks the handshake so a flushed head can never retire
    assign commit_valid = busy_q[head_q] && done_q[head_q] && !flush;
    assign commit_pc    = pc_q[head_q];
    assign commit_rd    = rd_q[head_q];
    assign commit_w     = w_q[head_q] && !exc_q[head_q];
    assign commit_store = store_q[head_q];
    assign commit_val   = val_q[head_q];
    assign commit_exc   = exc_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        exc_d   = exc_q;
        w_d     = w_q;
        store_d = store_q;
        pc_d    = pc_q;
        val_d   = val_q;
        rd_d    = rd_q;
        tag_i   = '0;

        alloc_fire  = alloc_valid && alloc_ready;
        commit_fire = commit_valid && commit_ready;
        clear_all   = flush || (commit_fire && exc_q[head_q]);

        if (clear_all) begin
            // done/exc are cleared too so a stale exception never shows at head 0
            busy_d  = '0;
            done_d  = '0;
            exc_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // highest channel first so the lowest index overwrites on a tag clash
            for (int i = NUM_CMP - 1; i >= 0; i--) begin
                tag_i = cmp_tag[i*TAG_W +: TAG_W];
                if (cmp_valid[i] && busy_q[tag_i]) begin
                    done_d[tag_i] = 1'b1;
                    exc_d[tag_i]  = cmp_exc[i];
                    val_d[tag_i]  = cmp_val[i*DATA_W +: DATA_W];
                end
            end
            if (commit_fire) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            // tail is never busy when alloc_ready=1, so completions above cannot hit it
            if (alloc_fire) begin
                busy_d[tail_q]  = 1'b1;
                done_d[tail_q]  = 1'b0;
                exc_d[tail_q]   = 1'b0;
                pc_d[tail_q]    = alloc_pc;
                rd_d[tail_q]    = alloc_rd;
                w_d[tail_q]     = alloc_w;
                store_d[tail_q] = alloc_store;
                tail_d          = tail_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            w_q     <= '0;
            store_q <= '0;
            pc_q    <= '{default: '0};
            val_q   <= '{default: '0};
            rd_q    <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            w_q     <= w_d;
            store_q <= store_d;
            pc_q    <= pc_d;
            val_q   <= val_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - self-checking bench for rob_multi against a queue-based program-order model
module tb_rob_multi;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_CMP = 3;
    localparam int TAG_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      alloc_valid, alloc_ready, alloc_w, alloc_store;
    logic [DATA_W-1:0]         alloc_pc;
    logic [REG_AW-1:0]         alloc_rd;
    logic [TAG_W-1:0]          alloc_tag;
    logic [NUM_CMP-1:0]        cmp_valid, cmp_exc;
    logic [NUM_CMP*TAG_W-1:0]  cmp_tag;
    logic [NUM_CMP*DATA_W-1:0] cmp_val;
    logic                      commit_valid, commit_ready, commit_w, commit_store, commit_exc;
    logic [DATA_W-1:0]         commit_pc, commit_val;
    logic [REG_AW-1:0]         commit_rd;
    logic                      flush;
    logic [TAG_W:0]            count;

    always #5 clk = ~clk;

    rob_multi #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_CMP(NUM_CMP), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_rd(alloc_rd), .alloc_w(alloc_w), .alloc_store(alloc_store), .alloc_tag(alloc_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_val(cmp_val), .cmp_exc(cmp_exc),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
        .commit_rd(commit_rd), .commit_w(commit_w), .commit_store(commit_store),
        .commit_val(commit_val), .commit_exc(commit_exc), .flush(flush), .count(count)
    );

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [4:0]  rd;
        bit          w;
        bit          store;
        bit          done;
        bit          exc;
        logic [31:0] val;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_pc = '0; alloc_rd = '0; alloc_w = 0; alloc_store = 0;
        cmp_valid = '0; cmp_tag = '0; cmp_val = '0; cmp_exc = '0;
        commit_ready = 0; flush = 0;
    endtask

    task automatic set_cmp(input int ch, input int tag, input logic [31:0] val, input bit exc);
        cmp_valid[ch]               = 1'b1;
        cmp_tag[ch*TAG_W +: TAG_W]  = tag[TAG_W-1:0];
        cmp_val[ch*DATA_W +: DATA_W] = val;
        cmp_exc[ch]                 = exc;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input bit w, input bit st);
        alloc_valid = 1; alloc_pc = pc; alloc_rd = rd; alloc_w = w; alloc_store = st;
    endtask

    task automatic model_clear();
        q.delete();
        m_tail = 0;
    endtask

    task automatic check_outputs();
        bit exp_cv;
        exp_cv = !flush && q.size() > 0 && q[0].done;
        chk("alloc_ready", alloc_ready, q.size() < DEPTH);
        chk("alloc_tag", alloc_tag, m_tail);
        chk("count", count, q.size());
        chk("count_max", count <= DEPTH, 1);
        chk("commit_valid", commit_valid, exp_cv);
        if (exp_cv) begin
            chk("commit_pc", commit_pc, q[0].pc);
            chk("commit_rd", commit_rd, q[0].rd);
            chk("commit_w", commit_w, q[0].w && !q[0].exc);
            chk("commit_store", commit_store, q[0].store);
            chk("commit_val", commit_val, q[0].val);
            chk("commit_exc", commit_exc, q[0].exc);
        end
    endtask

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_update();
        bit   do_alloc, do_commit, head_exc;
        bit   claimed [int];
        ent_t e;
        if (flush) begin
            model_clear();
            return;
        end
        do_alloc  = alloc_valid && q.size() < DEPTH;
        do_commit = q.size() > 0 && q[0].done && commit_ready;
        head_exc  = do_commit && q[0].exc;
        for (int ch = 0; ch < NUM_CMP; ch++) begin
            int t;
            t = int'(cmp_tag[ch*TAG_W +: TAG_W]);
            if (cmp_valid[ch] && !claimed.exists(t)) begin
                foreach (q[k]) begin
                    if (q[k].tag == t) begin
                        claimed[t] = 1;
                        q[k].done = 1;
                        q[k].val  = cmp_val[ch*DATA_W +: DATA_W];
                        q[k].exc  = cmp_exc[ch];
                    end
                end
            end
        end
        if (do_commit) begin
            void'(q.pop_front());
            if (head_exc) begin
                model_clear();
                return;
            end
        end
        if (do_alloc) begin
            e.tag = m_tail; e.pc = alloc_pc; e.rd = alloc_rd; e.w = alloc_w;
            e.store = alloc_store; e.done = 0; e.exc = 0; e.val = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [31:0] held_pc, held_val;
        bit          held;

        // reset / idle
        idle();
        reset = 0;
        #3;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_commit_exc", commit_exc, 0);
        chk("rst_commit_pc", commit_pc, 0);
        @(posedge clk); #1;
        reset = 1;
        model_clear();
        cycle();

        // fill to full with no commits
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(32'h100 + 4 * i, 5'(i + 1), 1, 0);
            settle();
            chk("fill_tag", alloc_tag, i);
            cycle();
        end
        set_alloc(32'h200, 5'd9, 1, 0);
        settle();
        chk("full_count", count, 4);
        chk("full_ready", alloc_ready, 0);
        cycle();
        chk("full_no_accept", count, 4);
        idle(); flush = 1; cycle(); idle();

        // out-of-order completion, in-order commit
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h300 + 4 * i, 5'(i + 1), 1, 0);
            cycle();
        end
        idle();
        set_cmp(0, 2, 30, 0); commit_ready = 1; cycle();
        idle(); commit_ready = 1;
        settle();
        chk("ooo_wait_head", commit_valid, 0);
        set_cmp(1, 0, 10, 0); cycle();
        idle(); commit_ready = 1;
        set_cmp(2, 1, 20, 0);
        settle();
        chk("ooo_c1_valid", commit_valid, 1);
        chk("ooo_c1_rd", commit_rd, 1);
        chk("ooo_c1_val", commit_val, 10);
        cycle();
        idle(); commit_ready = 1;
        settle();
        chk("ooo_c2_rd", commit_rd, 2);
        chk("ooo_c2_val", commit_val, 20);
        cycle();
        settle();
        chk("ooo_c3_rd", commit_rd, 3);
        chk("ooo_c3_val", commit_val, 30);
        cycle();
        settle();
        chk("ooo_empty", count, 0);

        // same-tag conflict between channels
        idle(); flush = 1; cycle(); idle();
        set_alloc(32'h400, 5'd4, 1, 0); cycle();
        set_alloc(32'h404, 5'd5, 1, 1); cycle();
        idle();
        set_cmp(1, 0, 7, 0); set_cmp(0, 1, 5, 0); set_cmp(2, 1, 9, 0);
        cycle();
        idle(); commit_ready = 1; cycle();
        settle();
        chk("conflict_val", commit_val, 5);
        chk("conflict_store", commit_store, 1);
        cycle();

        // wrap-around with toggling backpressure
        idle();
        held = 0; held_pc = '0; held_val = '0;
        for (int i = 0; i < 20; i++) begin
            idle();
            set_alloc($urandom, 5'($urandom_range(0, 31)), 1, 0);
            commit_ready = i[0];
            if (q.size() > 0) set_cmp(0, q[q.size()-1].tag, $urandom, 0);
            settle();
            if (held) begin
                chk("hold_pc", commit_pc, held_pc);
                chk("hold_val", commit_val, held_val);
            end
            held = commit_valid && !commit_ready;
            held_pc = commit_pc; held_val = commit_val;
            cycle();
        end

        // exception commit clears everything, same-cycle alloc dropped
        idle(); flush = 1; cycle(); idle();
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h500 + 4 * i, 5'(i + 1), 1, 0);
            cycle();
        end
        idle();
        set_cmp(0, 0, 32'hdead, 1); cycle();
        idle(); commit_ready = 1; set_alloc(32'h600, 5'd7, 1, 0);
        settle();
        chk("exc_commit_exc", commit_exc, 1);
        chk("exc_commit_w", commit_w, 0);
        cycle();
        idle();
        settle();
        chk("exc_after_count", count, 0);
        chk("exc_after_cv", commit_valid, 0);
        chk("exc_after_tag", alloc_tag, 0);
        cycle();

        // external flush with two done entries
        set_alloc(32'h700, 5'd1, 1, 0); cycle();
        set_alloc(32'h704, 5'd2, 1, 0); cycle();
        idle(); set_cmp(0, 0, 1, 0); set_cmp(1, 1, 2, 0); cycle();
        idle(); commit_ready = 1; flush = 1;
        settle();
        chk("flush_cv_mask", commit_valid, 0);
        cycle();
        idle();
        settle();
        chk("flush_count", count, 0);

        // asynchronous reset mid-operation
        set_alloc(32'h800, 5'd3, 1, 0); cycle();
        set_alloc(32'h804, 5'd4, 1, 0); cycle();
        idle();
        #2;
        reset = 0;
        #1;
        chk("areset_count", count, 0);
        chk("areset_ready", alloc_ready, 1);
        chk("areset_tag", alloc_tag, 0);
        model_clear();
        @(posedge clk); #1;
        reset = 1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 9) < 7)
                set_alloc($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            commit_ready = ($urandom_range(0, 9) < 6);
            for (int ch = 0; ch < NUM_CMP; ch++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int t;
                    t = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag
                                       : int'($urandom_range(0, DEPTH - 1));
                    set_cmp(ch, t, $urandom, $urandom_range(0, 11) == 0);
                end
            end
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
